// File: rtl/regfile_port_b_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// regfile_port_b_arbiter_pkg
//   Shared definitions for the register-file port-B arbiter:
//     - REGB_ADDRX_ARGB : port-B address-select code that selects the
//                         register named by the ARGB_X field
//     - rba_state_e     : arbiter FSM state encoding (3 bits)
//     - regb_port_t     : one complete set of port-B control/data signals
// ----------------------------------------------------------------------------
package regfile_port_b_arbiter_pkg;

    // Address-select code meaning "use the ARGB_X register field".
    localparam logic [1:0] REGB_ADDRX_ARGB = 2'b01;

    typedef enum logic [2:0] {
        RBA_IDLE  = 3'd0,
        RBA_ARB   = 3'd1,
        RBA_STALL = 3'd2,
        RBA_ACC   = 3'd3,
        RBA_RD    = 3'd4,
        RBA_ACK   = 3'd5
    } rba_state_e;

    typedef struct packed {
        logic        en;
        logic        wen;
        logic [1:0]  addrx;
        logic [3:0]  argb;
        logic [15:0] din;
    } regb_port_t;

endpackage : regfile_port_b_arbiter_pkg

// File: rtl/regfile_port_b_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_port_b_arbiter
//   Shares register-file port B between the CPU datapath and a debug
//   requester. CPU port-B controls pass straight through except during the
//   single debug access cycle. If the CPU keeps port B busy for STARVE_LIMIT
//   cycles while debug waits, CPU_STALL is raised to force a free slot.
//   Port A is not involved.
//
// Ports
//   CLK, RESET            clock (rising edge), async active-high reset
//   CPU_REGB_*, CPU_ARGB_X,
//   CPU_DIN               CPU-side port-B request
//   REGB_DOUT             register-file port-B read data (1-cycle latency)
//   REGB_*, ARGB_X,
//   REGB_DIN              port-B controls to the register file
//   CPU_STALL             freezes CPU sequencing while a slot is forced
//   DBG_REQ/WE/ADDR/WDATA four-phase debug request
//   DBG_ACK, DBG_RDATA    debug completion and read result
//   COLLIDE               sticky: CPU used port B during a debug access
// ----------------------------------------------------------------------------
module regfile_port_b_arbiter
    import regfile_port_b_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned CNT_W        = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CPU_REGB_EN,
    input  logic        CPU_REGB_WEN,
    input  logic [1:0]  CPU_REGB_ADDRX,
    input  logic [3:0]  CPU_ARGB_X,
    input  logic [15:0] CPU_DIN,
    input  logic [15:0] REGB_DOUT,
    output logic        REGB_EN,
    output logic        REGB_WEN,
    output logic [1:0]  REGB_ADDRX,
    output logic [3:0]  ARGB_X,
    output logic [15:0] REGB_DIN,
    output logic        CPU_STALL,
    input  logic        DBG_REQ,
    input  logic        DBG_WE,
    input  logic [3:0]  DBG_ADDR,
    input  logic [15:0] DBG_WDATA,
    output logic        DBG_ACK,
    output logic [15:0] DBG_RDATA,
    output logic        COLLIDE
);

    rba_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              stall_q, stall_d;
    logic              ack_q, ack_d;
    logic [15:0]       rdata_q, rdata_d;
    logic              collide_q, collide_d;

    // One bit wider than the counter so the limit compare cannot overflow.
    logic [CNT_W:0]    cnt_inc;
    logic [CNT_W-1:0]  cnt_sat;
    logic              starve_hit;

    assign cnt_inc    = {1'b0, cnt_q} + (CNT_W+1)'(1);
    assign cnt_sat    = (cnt_q == '1) ? cnt_q : cnt_inc[CNT_W-1:0];
    assign starve_hit = (cnt_inc >= (CNT_W+1)'(STARVE_LIMIT));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_d   = stall_q;
        ack_d     = ack_q;
        rdata_d   = rdata_q;
        collide_d = collide_q;

        unique case (state_q)
            RBA_IDLE: begin
                if (DBG_REQ) begin
                    if (CPU_REGB_EN) begin
                        state_d = RBA_ARB;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        state_d = RBA_ACC;
                    end
                end
            end

            RBA_ARB: begin
                if (!CPU_REGB_EN) begin
                    state_d = RBA_ACC;
                end else begin
                    cnt_d = cnt_sat;
                    if (starve_hit) begin
                        state_d = RBA_STALL;
                        stall_d = 1'b1;
                    end
                end
            end

            // Stall stays asserted through ACC and RD; it drops on entry to ACK.
            RBA_STALL: begin
                state_d = RBA_ACC;
            end

            RBA_ACC: begin
                if (CPU_REGB_EN) begin
                    collide_d = 1'b1;
                end
                if (DBG_WE) begin
                    state_d = RBA_ACK;
                    ack_d   = 1'b1;
                    stall_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    state_d = RBA_RD;
                end
            end

            // Register file returns the ACC-cycle read data in this cycle.
            RBA_RD: begin
                rdata_d = REGB_DOUT;
                state_d = RBA_ACK;
                ack_d   = 1'b1;
                stall_d = 1'b0;
                cnt_d   = '0;
            end

            RBA_ACK: begin
                cnt_d = '0;
                if (!DBG_REQ) begin
                    state_d = RBA_IDLE;
                    ack_d   = 1'b0;
                end
            end

            default: begin
                state_d = RBA_IDLE;
                cnt_d   = '0;
                stall_d = 1'b0;
                ack_d   = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= RBA_IDLE;
            cnt_q     <= '0;
            stall_q   <= 1'b0;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
            collide_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stall_q   <= stall_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            collide_q <= collide_d;
        end
    end

    assign CPU_STALL = stall_q;
    assign DBG_ACK   = ack_q;
    assign DBG_RDATA = rdata_q;
    assign COLLIDE   = collide_q;

    // ------------------------------------------------------------------
    // Port-B output mux: debug owns the port only in the ACC cycle.
    // ------------------------------------------------------------------
    regb_port_t cpu_port, dbg_port, out_port;

    always_comb begin
        cpu_port.en    = CPU_REGB_EN;
        cpu_port.wen   = CPU_REGB_WEN;
        cpu_port.addrx = CPU_REGB_ADDRX;
        cpu_port.argb  = CPU_ARGB_X;
        cpu_port.din   = CPU_DIN;

        dbg_port.en    = 1'b1;
        dbg_port.wen   = DBG_WE;
        dbg_port.addrx = REGB_ADDRX_ARGB;
        dbg_port.argb  = DBG_ADDR;
        dbg_port.din   = DBG_WDATA;

        out_port = (state_q == RBA_ACC) ? dbg_port : cpu_port;
    end

    assign REGB_EN    = out_port.en;
    assign REGB_WEN   = out_port.wen;
    assign REGB_ADDRX = out_port.addrx;
    assign ARGB_X     = out_port.argb;
    assign REGB_DIN   = out_port.din;

endmodule : regfile_port_b_arbiter

// File: tb/tb_regfile_port_b_arbiter.sv
module tb_regfile_port_b_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        CPU_REGB_EN, CPU_REGB_WEN;
    logic [1:0]  CPU_REGB_ADDRX;
    logic [3:0]  CPU_ARGB_X;
    logic [15:0] CPU_DIN;
    logic [15:0] REGB_DOUT;
    logic        REGB_EN, REGB_WEN;
    logic [1:0]  REGB_ADDRX;
    logic [3:0]  ARGB_X;
    logic [15:0] REGB_DIN;
    logic        CPU_STALL;
    logic        DBG_REQ, DBG_WE;
    logic [3:0]  DBG_ADDR;
    logic [15:0] DBG_WDATA;
    logic        DBG_ACK;
    logic [15:0] DBG_RDATA;
    logic        COLLIDE;

    int n_cmp = 0;
    int n_bad = 0;

    // Register-file stand-in: synchronous write, registered read.
    logic [15:0] mem [16];
    always @(posedge CLK) begin
        if (REGB_EN) begin
            if (REGB_WEN) mem[ARGB_X] <= REGB_DIN;
            else          REGB_DOUT   <= mem[ARGB_X];
        end
    end

    always #5 CLK = ~CLK;

    regfile_port_b_arbiter #(
        .STARVE_LIMIT(8),
        .CNT_W       (4)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .CPU_REGB_EN   (CPU_REGB_EN),
        .CPU_REGB_WEN  (CPU_REGB_WEN),
        .CPU_REGB_ADDRX(CPU_REGB_ADDRX),
        .CPU_ARGB_X    (CPU_ARGB_X),
        .CPU_DIN       (CPU_DIN),
        .REGB_DOUT     (REGB_DOUT),
        .REGB_EN       (REGB_EN),
        .REGB_WEN      (REGB_WEN),
        .REGB_ADDRX    (REGB_ADDRX),
        .ARGB_X        (ARGB_X),
        .REGB_DIN      (REGB_DIN),
        .CPU_STALL     (CPU_STALL),
        .DBG_REQ       (DBG_REQ),
        .DBG_WE        (DBG_WE),
        .DBG_ADDR      (DBG_ADDR),
        .DBG_WDATA     (DBG_WDATA),
        .DBG_ACK       (DBG_ACK),
        .DBG_RDATA     (DBG_RDATA),
        .COLLIDE       (COLLIDE)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        CPU_REGB_EN = 1'b0; CPU_REGB_WEN = 1'b0; CPU_REGB_ADDRX = 2'b00;
        CPU_ARGB_X = 4'h0; CPU_DIN = 16'h0000;
        DBG_REQ = 1'b0; DBG_WE = 1'b0; DBG_ADDR = 4'h0; DBG_WDATA = 16'h0000;
        step(); step();
        n_cmp++; if (CPU_STALL !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b, expected 0", CPU_STALL); end
        n_cmp++; if (DBG_ACK !== 1'b0) begin n_bad++; $display("FAIL rst_ack: got %b, expected 0", DBG_ACK); end
        n_cmp++; if (DBG_RDATA !== 16'h0000) begin n_bad++; $display("FAIL rst_rdata: got %h, expected 0000", DBG_RDATA); end
        n_cmp++; if (COLLIDE !== 1'b0) begin n_bad++; $display("FAIL rst_collide: got %b, expected 0", COLLIDE); end
        CPU_REGB_EN = 1'b1; CPU_REGB_ADDRX = 2'b10; CPU_ARGB_X = 4'hA; CPU_DIN = 16'h5A5A;
        #1;
        n_cmp++; if ({REGB_EN, REGB_WEN, REGB_ADDRX, ARGB_X, REGB_DIN} !== {1'b1, 1'b0, 2'b10, 4'hA, 16'h5A5A})
            begin n_bad++; $display("FAIL rst_passthru: got %b %b %b %h %h, expected 1 0 10 a 5a5a", REGB_EN, REGB_WEN, REGB_ADDRX, ARGB_X, REGB_DIN); end
        RESET = 1'b0;
        // Preload R3 and R7 through the CPU pass-through path.
        CPU_REGB_WEN = 1'b1; CPU_ARGB_X = 4'h3; CPU_DIN = 16'h1234;
        step();
        CPU_ARGB_X = 4'h7; CPU_DIN = 16'h7777;
        step();
        CPU_REGB_EN = 1'b0; CPU_REGB_WEN = 1'b0;
        n_cmp++; if (mem[3] !== 16'h1234) begin n_bad++; $display("FAIL preload_r3: got %h, expected 1234", mem[3]); end
    endtask

    task automatic test_free_write();
        DBG_REQ = 1'b1; DBG_WE = 1'b1; DBG_ADDR = 4'h5; DBG_WDATA = 16'hBEEF;
        step(); // ACC
        n_cmp++; if ({REGB_EN, REGB_WEN, REGB_ADDRX, ARGB_X, REGB_DIN} !== {1'b1, 1'b1, 2'b01, 4'h5, 16'hBEEF})
            begin n_bad++; $display("FAIL fw_acc_port: got %b %b %b %h %h, expected 1 1 01 5 beef", REGB_EN, REGB_WEN, REGB_ADDRX, ARGB_X, REGB_DIN); end
        n_cmp++; if ({DBG_ACK, CPU_STALL} !== 2'b00) begin n_bad++; $display("FAIL fw_acc_ack_stall: got %b, expected 00", {DBG_ACK, CPU_STALL}); end
        step(); // ACK at +2
        n_cmp++; if ({DBG_ACK, CPU_STALL} !== 2'b10) begin n_bad++; $display("FAIL fw_ack: got ack,stall=%b, expected 10", {DBG_ACK, CPU_STALL}); end
        n_cmp++; if (REGB_EN !== 1'b0) begin n_bad++; $display("FAIL fw_ack_port: got %b, expected 0", REGB_EN); end
        n_cmp++; if (mem[5] !== 16'hBEEF) begin n_bad++; $display("FAIL fw_mem: got %h, expected beef", mem[5]); end
        DBG_REQ = 1'b0;
        step();
        n_cmp++; if (DBG_ACK !== 1'b0) begin n_bad++; $display("FAIL fw_release: got %b, expected 0", DBG_ACK); end
    endtask

    task automatic test_free_read();
        DBG_REQ = 1'b1; DBG_WE = 1'b0; DBG_ADDR = 4'h3; DBG_WDATA = 16'h0000;
        step(); // ACC
        n_cmp++; if ({REGB_EN, REGB_WEN, ARGB_X} !== {1'b1, 1'b0, 4'h3})
            begin n_bad++; $display("FAIL fr_acc_port: got %b %b %h, expected 1 0 3", REGB_EN, REGB_WEN, ARGB_X); end
        step(); // RD
        n_cmp++; if (DBG_ACK !== 1'b0) begin n_bad++; $display("FAIL fr_rd_ack: got %b, expected 0", DBG_ACK); end
        step(); // ACK at +3
        n_cmp++; if (DBG_ACK !== 1'b1) begin n_bad++; $display("FAIL fr_ack: got %b, expected 1", DBG_ACK); end
        n_cmp++; if (DBG_RDATA !== 16'h1234) begin n_bad++; $display("FAIL fr_rdata: got %h, expected 1234", DBG_RDATA); end
        step(); // still held
        n_cmp++; if (DBG_ACK !== 1'b1) begin n_bad++; $display("FAIL fr_ack_hold: got %b, expected 1", DBG_ACK); end
        DBG_REQ = 1'b0;
        step();
        n_cmp++; if (DBG_ACK !== 1'b0) begin n_bad++; $display("FAIL fr_release: got %b, expected 0", DBG_ACK); end
        n_cmp++; if (CPU_STALL !== 1'b0) begin n_bad++; $display("FAIL fr_stall: got %b, expected 0", CPU_STALL); end
    endtask

    task automatic test_starvation();
        CPU_REGB_EN = 1'b1; CPU_REGB_WEN = 1'b0; CPU_REGB_ADDRX = 2'b10; CPU_ARGB_X = 4'hC;
        DBG_REQ = 1'b1; DBG_WE = 1'b0; DBG_ADDR = 4'h7;
        for (int i = 1; i <= 7; i++) begin
            step();
            n_cmp++; if (CPU_STALL !== 1'b0) begin n_bad++; $display("FAIL st_early_stall[%0d]: got %b, expected 0", i, CPU_STALL); end
        end
        n_cmp++; if ({REGB_EN, ARGB_X} !== {1'b1, 4'hC}) begin n_bad++; $display("FAIL st_arb_pass: got %b %h, expected 1 c", REGB_EN, ARGB_X); end
        step(); // +8: STALL
        n_cmp++; if (CPU_STALL !== 1'b1) begin n_bad++; $display("FAIL st_stall_rise: got %b, expected 1", CPU_STALL); end
        CPU_REGB_EN = 1'b0;
        step(); // ACC
        n_cmp++; if ({CPU_STALL, REGB_EN, REGB_WEN, ARGB_X} !== {1'b1, 1'b1, 1'b0, 4'h7})
            begin n_bad++; $display("FAIL st_acc: got %b %b %b %h, expected 1 1 0 7", CPU_STALL, REGB_EN, REGB_WEN, ARGB_X); end
        step(); // RD
        n_cmp++; if ({CPU_STALL, DBG_ACK} !== 2'b10) begin n_bad++; $display("FAIL st_rd: got stall,ack=%b, expected 10", {CPU_STALL, DBG_ACK}); end
        step(); // ACK
        n_cmp++; if ({CPU_STALL, DBG_ACK} !== 2'b01) begin n_bad++; $display("FAIL st_ack: got stall,ack=%b, expected 01", {CPU_STALL, DBG_ACK}); end
        n_cmp++; if (DBG_RDATA !== 16'h7777) begin n_bad++; $display("FAIL st_rdata: got %h, expected 7777", DBG_RDATA); end
        n_cmp++; if (COLLIDE !== 1'b0) begin n_bad++; $display("FAIL st_collide: got %b, expected 0", COLLIDE); end
        DBG_REQ = 1'b0;
        step();
        n_cmp++; if (DBG_ACK !== 1'b0) begin n_bad++; $display("FAIL st_release: got %b, expected 0", DBG_ACK); end
    endtask

    task automatic test_late_slot();
        CPU_REGB_EN = 1'b1; CPU_REGB_WEN = 1'b0; CPU_ARGB_X = 4'h1;
        DBG_REQ = 1'b1; DBG_WE = 1'b1; DBG_ADDR = 4'h9; DBG_WDATA = 16'h0909;
        step(); step(); step();
        n_cmp++; if ({CPU_STALL, REGB_EN, ARGB_X} !== {1'b0, 1'b1, 4'h1}) begin n_bad++; $display("FAIL ls_wait: got %b %b %h, expected 0 1 1", CPU_STALL, REGB_EN, ARGB_X); end
        CPU_REGB_EN = 1'b0;
        step(); // first free cycle seen -> ACC
        n_cmp++; if ({CPU_STALL, REGB_EN, REGB_WEN, ARGB_X, REGB_DIN} !== {1'b0, 1'b1, 1'b1, 4'h9, 16'h0909})
            begin n_bad++; $display("FAIL ls_acc: got %b %b %b %h %h, expected 0 1 1 9 0909", CPU_STALL, REGB_EN, REGB_WEN, ARGB_X, REGB_DIN); end
        step();
        n_cmp++; if ({DBG_ACK, CPU_STALL} !== 2'b10) begin n_bad++; $display("FAIL ls_ack: got %b, expected 10", {DBG_ACK, CPU_STALL}); end
        n_cmp++; if (mem[9] !== 16'h0909) begin n_bad++; $display("FAIL ls_mem: got %h, expected 0909", mem[9]); end
        DBG_REQ = 1'b0;
        step();
        n_cmp++; if (DBG_ACK !== 1'b0) begin n_bad++; $display("FAIL ls_release: got %b, expected 0", DBG_ACK); end
    endtask

    task automatic test_collision();
        CPU_REGB_EN = 1'b1; CPU_REGB_WEN = 1'b1; CPU_ARGB_X = 4'hE; CPU_DIN = 16'hFFFF;
        DBG_REQ = 1'b1; DBG_WE = 1'b1; DBG_ADDR = 4'h2; DBG_WDATA = 16'hC0DE;
        for (int i = 1; i <= 8; i++) step();
        n_cmp++; if (CPU_STALL !== 1'b1) begin n_bad++; $display("FAIL co_stall: got %b, expected 1", CPU_STALL); end
        step(); // ACC with CPU still enabled
        n_cmp++; if ({REGB_EN, REGB_WEN, ARGB_X, REGB_DIN} !== {1'b1, 1'b1, 4'h2, 16'hC0DE})
            begin n_bad++; $display("FAIL co_acc_port: got %b %b %h %h, expected 1 1 2 c0de", REGB_EN, REGB_WEN, ARGB_X, REGB_DIN); end
        n_cmp++; if (COLLIDE !== 1'b0) begin n_bad++; $display("FAIL co_pre: got %b, expected 0", COLLIDE); end
        step(); // ACK
        n_cmp++; if ({COLLIDE, DBG_ACK, CPU_STALL} !== 3'b110) begin n_bad++; $display("FAIL co_ack: got collide,ack,stall=%b, expected 110", {COLLIDE, DBG_ACK, CPU_STALL}); end
        n_cmp++; if (mem[2] !== 16'hC0DE) begin n_bad++; $display("FAIL co_mem: got %h, expected c0de", mem[2]); end
        CPU_REGB_EN = 1'b0; CPU_REGB_WEN = 1'b0; DBG_REQ = 1'b0;
        step(); step(); step();
        n_cmp++; if ({COLLIDE, DBG_ACK} !== 2'b10) begin n_bad++; $display("FAIL co_sticky: got collide,ack=%b, expected 10", {COLLIDE, DBG_ACK}); end
    endtask

    task automatic test_reset_during_rd();
        CPU_REGB_EN = 1'b1; CPU_REGB_WEN = 1'b0; CPU_ARGB_X = 4'h0;
        DBG_REQ = 1'b1; DBG_WE = 1'b1; DBG_ADDR = 4'h3; DBG_WDATA = 16'hDEAD;
        DBG_WE = 1'b0;
        for (int i = 1; i <= 8; i++) step();
        CPU_REGB_EN = 1'b0;
        step(); // ACC
        step(); // RD
        n_cmp++; if ({CPU_STALL, COLLIDE, DBG_ACK} !== 3'b110) begin n_bad++; $display("FAIL rr_pre: got stall,collide,ack=%b, expected 110", {CPU_STALL, COLLIDE, DBG_ACK}); end
        n_cmp++; if (DBG_RDATA !== 16'h7777) begin n_bad++; $display("FAIL rr_pre_rdata: got %h, expected 7777", DBG_RDATA); end
        #2 RESET = 1'b1;
        #1;
        n_cmp++; if ({CPU_STALL, COLLIDE, DBG_ACK} !== 3'b000) begin n_bad++; $display("FAIL rr_async: got stall,collide,ack=%b, expected 000", {CPU_STALL, COLLIDE, DBG_ACK}); end
        n_cmp++; if (DBG_RDATA !== 16'h0000) begin n_bad++; $display("FAIL rr_async_rdata: got %h, expected 0000", DBG_RDATA); end
        CPU_ARGB_X = 4'h4;
        #1;
        n_cmp++; if ({REGB_EN, ARGB_X} !== {1'b0, 4'h4}) begin n_bad++; $display("FAIL rr_passthru: got %b %h, expected 0 4", REGB_EN, ARGB_X); end
        DBG_REQ = 1'b0;
        step(); step();
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if ({REGB_EN, DBG_ACK} !== 2'b00) begin n_bad++; $display("FAIL rr_post[%0d]: got en,ack=%b, expected 00", i, {REGB_EN, DBG_ACK}); end
        end
        n_cmp++; if (mem[3] !== 16'h1234) begin n_bad++; $display("FAIL rr_mem: got %h, expected 1234", mem[3]); end
    endtask

    initial begin
        test_reset();
        test_free_write();
        test_free_read();
        test_starvation();
        test_late_slot();
        test_collision();
        test_reset_during_rd();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_regfile_port_b_arbiter

// File: doc/regfile_port_b_arbiter.md
Name:
regfile_port_b_arbiter

Overview:
- Shares register-file port B between the CPU datapath and a debug/monitor requester.
- Sits between control/decode and register_file. Passes CPU port-B controls straight through when no debug access is in progress. Grants debug single-register reads and writes in idle port-B slots.
- If the CPU holds port B for STARVE_LIMIT cycles, the block asserts CPU_STALL to force a slot.
- Port A is never touched.

Parameters:
- STARVE_LIMIT, 8: consecutive blocked cycles before a stall is forced (range 1..2^CNT_W-1).
- CNT_W, 4: starvation counter width.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- CPU_REGB_EN  in  1  CPU port-B clock enable.
- CPU_REGB_WEN  in  1  CPU port-B write enable.
- CPU_REGB_ADDRX  in  2  CPU port-B address select.
- CPU_ARGB_X  in  4  CPU port-B register field.
- CPU_DIN  in  16  CPU port-B write data (memory bus).
- REGB_DOUT  in  16  register-file port-B read data (registered, 1-cycle latency).
- REGB_EN  out  1  to register_file.
- REGB_WEN  out  1  to register_file.
- REGB_ADDRX  out  2  to register_file.
- ARGB_X  out  4  to register_file.
- REGB_DIN  out  16  to register_file DIN.
- CPU_STALL  out  1  freezes CPU sequencing; CPU guarantees CPU_REGB_EN=0 from the cycle after CPU_STALL rises.
- DBG_REQ  in  1  debug request (four-phase).
- DBG_WE  in  1  1=write, 0=read; stable while DBG_REQ=1.
- DBG_ADDR  in  4  register number.
- DBG_WDATA  in  16  write data.
- DBG_ACK  out  1  access complete.
- DBG_RDATA  out  16  read result; valid while DBG_ACK=1.
- COLLIDE  out  1  sticky error flag.

Behaviour:
- Reset (async, active-high): state=IDLE, counter=0, CPU_STALL=0, DBG_ACK=0, DBG_RDATA=0, COLLIDE=0. Port-B outputs are in pass-through. Reset mid-access abandons the access; no write is issued after reset deasserts.
- Pass-through (every state except ACC): REGB_* = CPU_* combinationally.
- IDLE:
  - DBG_REQ=1 and CPU_REGB_EN=0 -> ACC.
  - DBG_REQ=1 and CPU_REGB_EN=1 -> ARB, counter=1.
- ARB:
  - CPU_REGB_EN=0 -> ACC.
  - Otherwise counter++. When counter reaches STARVE_LIMIT -> STALL.
- STALL: CPU_STALL=1 for one cycle -> ACC.
- ACC (exactly one cycle):
  - Drives REGB_EN=1, REGB_WEN=DBG_WE, REGB_ADDRX=`REGB_ADDRX_ARGB, ARGB_X=DBG_ADDR, REGB_DIN=DBG_WDATA.
  - CPU_STALL=1 if entered from STALL; otherwise 0.
  - If CPU_REGB_EN=1 in this cycle, debug still wins and COLLIDE sets to 1.
  - Read -> RD. Write -> ACK.
- RD: CPU_STALL keeps its ACC value. Capture REGB_DOUT into DBG_RDATA -> ACK.
- ACK:
  - DBG_ACK=1, CPU_STALL=0, counter=0.
  - Hold until DBG_REQ=0, then IDLE with DBG_ACK=0 next cycle.
- Latency when the slot is free: write ACK at cycle +2 after DBG_REQ; read ACK at cycle +3.
- The counter saturates and never wraps.
- DBG_REQ dropping before ACK is a protocol violation. The FSM completes the access regardless.
- COLLIDE clears only on reset.

Decomposition:
- The shared constants include gains a state encoding: RBA_IDLE, RBA_ARB, RBA_STALL, RBA_ACC, RBA_RD, RBA_ACK (3 bits).
- Uses the existing `REGB_ADDRX_ARGB encoding.
- No sub-module. The FSM, counter and output mux stay in one file.

Test Plan:
- Free-slot write: CPU_REGB_EN=0, DBG write R5=0xBEEF -> ACC cycle shows REGB_EN=1, WEN=1, ARGB_X=5, REGB_DIN=0xBEEF; DBG_ACK at +2; CPU_STALL never high.
- Free-slot read: R3 preloaded 0x1234 -> DBG_RDATA=0x1234 with DBG_ACK at +3; ACK held until DBG_REQ drops, then cleared next cycle.
- Starvation: CPU_REGB_EN=1 continuously, STARVE_LIMIT=8 -> CPU_STALL rises 8 cycles after the request and stays high through ACC/RD; access completes; CPU_STALL=0 in ACK.
- Late free slot: CPU_REGB_EN=1 for 3 cycles then 0 -> access in the first free cycle; no stall; counter reset after ACK.
- Collision: CPU keeps CPU_REGB_EN=1 during a forced ACC -> debug values win on the port; COLLIDE=1 and stays set until RESET.
- Async reset during RD: RESET pulses mid-access -> outputs zero immediately without a clock edge; pass-through restored; no spurious write after release.
